// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for a stable clock-source lock, then releases a
// chain of downstream reset domains one at a time. Each domain must
// acknowledge on ready_i before the next one is released. A domain that
// does not acknowledge in time parks the block in a fault state until an
// explicit restart.
module reset_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int LOCK_DELAY    = 20,
    parameter int STAGE_DELAY   = 16,
    parameter int READY_TIMEOUT = 1000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  pll_locked_i,
    input  logic [NUM_STAGES-1:0] ready_i,
    input  logic                  restart_i,
    output logic [NUM_STAGES-1:0] rst_o,
    output logic                  done_o,
    output logic                  fault_o,
    output logic [2:0]            stage_o
);

    // One shared down/up counter serves lock filtering, ready timeout and
    // the inter-stage gap, so it is sized for the largest of the three.
    localparam int MAX_A = (LOCK_DELAY > STAGE_DELAY) ? LOCK_DELAY : STAGE_DELAY;
    localparam int MAX_V = (MAX_A > READY_TIMEOUT) ? MAX_A : READY_TIMEOUT;
    localparam int CW    = $clog2(MAX_V + 1);

    localparam logic [CW-1:0]         C_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]         C_ONE  = CW'(1'b1);
    localparam logic [CW-1:0]         C_LOCK = CW'(LOCK_DELAY);
    localparam logic [CW-1:0]         C_GAP  = CW'(STAGE_DELAY);
    localparam logic [CW-1:0]         C_TMO  = CW'(READY_TIMEOUT);
    localparam logic [2:0]            C_LAST = 3'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] W_ONES = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] W_ZERO = {NUM_STAGES{1'b0}};
    localparam logic [NUM_STAGES-1:0] W_ONE  = NUM_STAGES'(1'b1);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        RELEASE    = 3'd1,
        WAIT_READY = 3'd2,
        GAP        = 3'd3,
        RUN        = 3'd4,
        FAULT      = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_nxt;
    logic [2:0]              r_stage;
    logic [2:0]              w_stage_nxt;
    logic [NUM_STAGES-1:0]   r_rst;
    logic [NUM_STAGES-1:0]   w_rst_nxt;
    logic                    r_done;
    logic                    r_fault;
    logic                    w_ready;

    // Acknowledge of the stage currently awaited; other stages' bits are ignored.
    assign w_ready = |(ready_i & (W_ONE << r_stage));

    // Next-state, counter, stage index and reset-vector computation.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stage_nxt = r_stage;
        w_rst_nxt   = r_rst;
        case (r_state)
            WAIT_LOCK: begin
                w_rst_nxt   = W_ONES;
                w_stage_nxt = 3'd0;
                if (!pll_locked_i) begin
                    w_cnt_nxt = C_ZERO;
                end else if (r_cnt >= C_LOCK) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = C_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            RELEASE: begin
                w_rst_nxt   = r_rst & ~(W_ONE << r_stage);
                w_cnt_nxt   = C_TMO;
                w_state_nxt = WAIT_READY;
            end
            WAIT_READY: begin
                // Acknowledge is checked first so it beats a simultaneous timeout.
                if (w_ready) begin
                    if (r_stage >= C_LAST) begin
                        w_state_nxt = RUN;
                        w_rst_nxt   = W_ZERO;
                        w_cnt_nxt   = C_ZERO;
                    end else begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = C_GAP;
                    end
                end else if (r_cnt <= C_ONE) begin
                    w_state_nxt = FAULT;
                    w_rst_nxt   = W_ONES;
                    w_cnt_nxt   = C_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            GAP: begin
                if (r_cnt == C_ZERO) begin
                    w_state_nxt = RELEASE;
                    if (r_stage < C_LAST) begin
                        w_stage_nxt = r_stage + 3'd1;
                    end else begin
                        w_stage_nxt = C_LAST;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            RUN: begin
                w_rst_nxt = W_ZERO;
                if (restart_i) begin
                    w_state_nxt = WAIT_LOCK;
                    w_rst_nxt   = W_ONES;
                    w_cnt_nxt   = C_ZERO;
                    w_stage_nxt = 3'd0;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            FAULT: begin
                w_rst_nxt = W_ONES;
                if (restart_i) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = C_ZERO;
                    w_stage_nxt = 3'd0;
                end else begin
                    w_state_nxt = FAULT;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
                w_rst_nxt   = W_ONES;
                w_cnt_nxt   = C_ZERO;
                w_stage_nxt = 3'd0;
            end
        endcase

        // Losing lock mid-sequence or in RUN restarts everything and outranks
        // ready, timeout and restart.
        if (!pll_locked_i && (r_state != WAIT_LOCK) && (r_state != FAULT)) begin
            w_state_nxt = WAIT_LOCK;
            w_rst_nxt   = W_ONES;
            w_cnt_nxt   = C_ZERO;
            w_stage_nxt = 3'd0;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= C_ZERO;
            r_stage <= 3'd0;
            r_rst   <= W_ONES;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stage <= w_stage_nxt;
            r_rst   <= w_rst_nxt;
            // done follows one cycle after RUN is entered and drops with it.
            r_done  <= (r_state == RUN) && (w_state_nxt == RUN);
            r_fault <= (w_state_nxt == FAULT);
        end
    end

    assign rst_o   = r_rst;
    assign done_o  = r_done;
    assign fault_o = r_fault;
    assign stage_o = r_stage;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: each stimulus step pushes the
// outputs it should cause, tagged with the clock edge after which they must
// be visible; a negedge monitor pops and compares them.
module tb_reset_sequencer;

    localparam int NS = 3;
    localparam int LD = 4;
    localparam int SD = 2;
    localparam int RT = 5;

    localparam int S_RST  = 0;
    localparam int S_DONE = 1;
    localparam int S_FLT  = 2;
    localparam int S_STG  = 3;

    typedef struct {
        int         due;
        string      tag;
        int         sig;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          pll_locked_i;
    logic          restart_i;
    logic [NS-1:0] ready_i;
    logic [NS-1:0] rst_o;
    logic          done_o;
    logic          fault_o;
    logic [2:0]    stage_o;

    logic [NS-1:0] r_echo = 3'b000;
    logic [NS-1:0] r_mask = 3'b111;
    logic [NS-1:0] r_frc  = 3'b000;

    int cyc      = 0;
    int n_total  = 0;
    int n_bad    = 0;
    int last_due = 0;

    reset_sequencer #(
        .NUM_STAGES   (NS),
        .LOCK_DELAY   (LD),
        .STAGE_DELAY  (SD),
        .READY_TIMEOUT(RT)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .pll_locked_i(pll_locked_i),
        .ready_i     (ready_i),
        .restart_i   (restart_i),
        .rst_o       (rst_o),
        .done_o      (done_o),
        .fault_o     (fault_o),
        .stage_o     (stage_o)
    );

    always #5 clk_i = ~clk_i;

    // Edge counter: value is the number of rising edges seen so far.
    always @(posedge clk_i) cyc <= cyc + 1;

    // Downstream domains acknowledge one cycle after their reset drops.
    always @(posedge clk_i) r_echo <= ~rst_o;

    assign ready_i = (r_echo & r_mask) | r_frc;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void push(input int due, input string tag, input int sig, input logic [7:0] val);
        exp_t e;
        e.due = due;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb_q.push_back(e);
        if (due > last_due) last_due = due;
    endfunction

    function automatic logic [7:0] obs(input int sig);
        case (sig)
            S_RST:   return 8'(rst_o);
            S_DONE:  return 8'(done_o);
            S_FLT:   return 8'(fault_o);
            default: return 8'(stage_o);
        endcase
    endfunction

    // Compare every expectation that falls due after the latest rising edge.
    always @(negedge clk_i) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                check_eq(sb_q[i].tag, obs(sb_q[i].sig), sb_q[i].val);
                sb_q.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    // Expected full release sequence when lock is first sampled high at edge t0.
    function automatic void push_seq(input int t0);
        logic [NS-1:0] ones;
        logic [NS-1:0] pre;
        logic [NS-1:0] post;
        int f;
        int r;
        ones = 3'b111;
        f = t0 + LD + 1;
        r = 0;
        for (int k = 0; k < NS; k++) begin
            pre  = ones << k;
            post = ones << (k + 1);
            push(f - 1, "rst_before_release", S_RST, 8'(pre));
            push(f,     "rst_after_release",  S_RST, 8'(post));
            push(f,     "stage_idx",          S_STG, 8'(k));
            r = f + 2;
            f = r + SD + 2;
        end
        push(r,     "done_not_yet", S_DONE, 8'd0);
        push(r + 1, "done_high",    S_DONE, 8'd1);
        push(r + 1, "fault_clear",  S_FLT,  8'd0);
    endfunction

    // Hard stop in case the run stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        int n;
        int f0;
        int f1;
        int f2;
        int r1;
        int ff;

        reset_i      = 1'b1;
        pll_locked_i = 1'b1;
        restart_i    = 1'b0;

        // Reset held for three edges with lock already present.
        for (int e = 1; e <= 3; e++) begin
            push(e, "reset_rst",   S_RST,  8'h07);
            push(e, "reset_done",  S_DONE, 8'd0);
            push(e, "reset_fault", S_FLT,  8'd0);
            push(e, "reset_stage", S_STG,  8'd0);
        end
        step_to(3);

        // Nominal sequence; a restart during GAP must be ignored.
        reset_i = 1'b0;
        t0 = cyc + 1;
        push_seq(t0);
        step_to(t0 + LD + 3);
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        step_to(last_due + 2);

        // Lock lost for one cycle while running.
        pll_locked_i = 1'b0;
        push(cyc + 1, "lockloss_rst",  S_RST,  8'h07);
        push(cyc + 1, "lockloss_done", S_DONE, 8'd0);
        step();
        pll_locked_i = 1'b1;
        push_seq(cyc + 1);
        step_to(last_due + 2);

        // Lock glitch: 3 high, 1 low, then stable.
        reset_i      = 1'b1;
        pll_locked_i = 1'b0;
        step();
        reset_i      = 1'b0;
        pll_locked_i = 1'b1;
        n = cyc;
        push(n + 1 + LD + 1, "glitch_hold",  S_RST, 8'h07);
        push(n + 5 + LD - 1, "glitch_hold2", S_RST, 8'h07);
        push_seq(n + 5);
        step();
        step();
        step();
        pll_locked_i = 1'b0;
        step();
        pll_locked_i = 1'b1;
        step_to(last_due + 2);

        // Stage 1 never acknowledges: timeout fault, then restart.
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        r_mask  = 3'b101;
        t0 = cyc + 1;
        f0 = t0 + LD + 1;
        f1 = f0 + 2 + SD + 2;
        ff = f1 + RT;
        push(f0,     "flt_rst_s0",   S_RST, 8'h06);
        push(f1,     "flt_rst_s1",   S_RST, 8'h04);
        push(ff - 1, "fault_early",  S_FLT, 8'd0);
        push(ff,     "fault_set",    S_FLT, 8'd1);
        push(ff,     "fault_stage",  S_STG, 8'd1);
        push(ff,     "fault_rst",    S_RST, 8'h07);
        push(ff,     "fault_done",   S_DONE, 8'd0);
        push(ff + 2, "fault_hold",   S_FLT, 8'd1);
        push(ff + 2, "fault_stage2", S_STG, 8'd1);
        step_to(ff + 2);
        restart_i = 1'b1;
        r_mask    = 3'b111;
        push(ff + 3, "restart_fault", S_FLT, 8'd0);
        push(ff + 3, "restart_rst",   S_RST, 8'h07);
        step();
        restart_i = 1'b0;
        push_seq(cyc + 1);
        step_to(last_due + 2);

        // Reset pulse while in GAP after stage 1 acknowledged.
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        t0 = cyc + 1;
        f0 = t0 + LD + 1;
        f1 = f0 + 2 + SD + 2;
        r1 = f1 + 2;
        push(f0, "gap_rst_s0", S_RST, 8'h06);
        push(f1, "gap_rst_s1", S_RST, 8'h04);
        push(r1, "gap_stage",  S_STG, 8'd1);
        step_to(r1);
        reset_i = 1'b1;
        push(r1 + 1, "gapreset_rst",   S_RST,  8'h07);
        push(r1 + 1, "gapreset_stage", S_STG,  8'd0);
        push(r1 + 1, "gapreset_done",  S_DONE, 8'd0);
        step();
        reset_i = 1'b0;
        push_seq(cyc + 1);
        step_to(last_due + 2);

        // Stage 1 acknowledges exactly on the timeout cycle: ready wins.
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        r_mask  = 3'b101;
        t0 = cyc + 1;
        f0 = t0 + LD + 1;
        f1 = f0 + 2 + SD + 2;
        f2 = f1 + RT + SD + 2;
        push(f1,          "edge_rst_s1",  S_RST,  8'h04);
        push(f1 + RT,     "edge_nofault", S_FLT,  8'd0);
        push(f1 + RT,     "edge_stage",   S_STG,  8'd1);
        push(f1 + RT + 1, "edge_nofault2", S_FLT, 8'd0);
        push(f2 - 1,      "edge_rst_pre", S_RST,  8'h04);
        push(f2,          "edge_rst_s2",  S_RST,  8'h00);
        push(f2,          "edge_stage2",  S_STG,  8'd2);
        push(f2 + 3,      "edge_done",    S_DONE, 8'd1);
        step_to(f1 + RT - 1);
        r_frc = 3'b010;
        step_to(last_due + 2);
        r_frc  = 3'b000;
        r_mask = 3'b111;

        check_eq("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
